// File: rtl/idx_buf_pkg.sv
// idx_buf_pkg: shared types for the index stream unpacker.
// Defaults describe 16-bit column indices packed four per word.
package idx_buf_pkg;

  localparam int IDX_W_DEF        = 16;
  localparam int IDX_PER_WORD_DEF = 4;
  localparam int CNT_W_DEF        =
    $clog2(IDX_PER_WORD_DEF + 1);
  localparam int WORD_W_DEF       =
    IDX_W_DEF * IDX_PER_WORD_DEF;

  typedef logic [IDX_W_DEF-1:0] idx_t;

  typedef enum logic {
    IDLE,
    EMIT
  } ustate_e;

  typedef struct packed {
    logic [WORD_W_DEF-1:0] word;
    logic [CNT_W_DEF-1:0]  cnt;
    logic                  last;
  } word_ent_t;

endpackage

// File: rtl/idx_word_fifo.sv
// idx_word_fifo: small word buffer ahead of the unpacker.
// Read data is combinational from the head slot.
module idx_word_fifo
  import idx_buf_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full && !clr;
  assign do_rd   = rd_en && !empty && !clr;
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset, level guards reads.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(do_wr) - LW'(do_rd);
    end
  end

endmodule

// File: rtl/index_stream_unpacker.sv
// index_stream_unpacker: buffers packed index words and
// emits one index per cycle, lane 0 first, with flow control.
module index_stream_unpacker
  import idx_buf_pkg::*;
#(
  parameter int IDX_W        = IDX_W_DEF,
  parameter int IDX_PER_WORD = IDX_PER_WORD_DEF,
  parameter int DEPTH        = 4,
  localparam int CNT_W  = $clog2(IDX_PER_WORD + 1),
  localparam int WORD_W = IDX_W * IDX_PER_WORD,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [CNT_W-1:0]  in_count,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic [LVL_W-1:0]  level
);

  localparam int LANE_W =
    (IDX_PER_WORD > 1) ? $clog2(IDX_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(IDX_PER_WORD);

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  cnt;
    logic              last;
  } ent_t;

  ent_t              wr_ent;
  ent_t              rd_ent;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;
  logic [CNT_W-1:0]  cnt_c;

  ustate_e           state;
  logic [WORD_W-1:0] cur_word;
  logic [CNT_W-1:0]  cur_cnt;
  logic              cur_last;
  logic [LANE_W-1:0] lane;
  logic [LANE_W-1:0] lane_nx;
  logic [IDX_W-1:0]  lanes [IDX_PER_WORD];
  logic              fire;
  logic              at_end;
  logic              nx_end;

  assign cnt_c =
    (in_count > CNT_MAX) ? CNT_MAX : in_count;

  // Full state is registered; flush blocks new words.
  assign in_ready = !full && !flush;

  // Zero-count words are accepted but never stored.
  assign wr_en  = in_valid && in_ready && (cnt_c != '0);
  assign wr_ent = '{word: in_word,
                    cnt:  cnt_c,
                    last: in_last};

  idx_word_fifo #(
    .W     ($bits(ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (wr_en),
    .wr_data (wr_ent),
    .rd_en   (rd_en),
    .rd_data (rd_ent),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // Split the held word into lane slices.
  always_comb begin
    for (int k = 0; k < IDX_PER_WORD; k++) begin
      lanes[k] = cur_word[k*IDX_W +: IDX_W];
    end
  end

  assign lane_nx = lane + LANE_W'(1);
  assign at_end  =
    (CNT_W'(lane) == cur_cnt - CNT_W'(1));
  assign nx_end  =
    (CNT_W'(lane_nx) == cur_cnt - CNT_W'(1));
  assign fire    = out_valid && out_ready;

  // Pop when idle, or on the final lane's handshake so
  // consecutive words stream without a bubble.
  assign rd_en = !flush && !empty &&
                 ((state == IDLE) || (fire && at_end));

  // Unpack FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
      cur_word  <= '0;
      cur_cnt   <= '0;
      cur_last  <= 1'b0;
      lane      <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
      cur_word  <= '0;
      cur_cnt   <= '0;
      cur_last  <= 1'b0;
      lane      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_en) begin
            state     <= EMIT;
            out_valid <= 1'b1;
            cur_word  <= rd_ent.word;
            cur_cnt   <= rd_ent.cnt;
            cur_last  <= rd_ent.last;
            lane      <= '0;
            out_index <= rd_ent.word[IDX_W-1:0];
            out_last  <= rd_ent.last &&
                         (rd_ent.cnt == CNT_W'(1));
          end
        end
        EMIT: begin
          if (fire) begin
            if (!at_end) begin
              lane      <= lane_nx;
              out_index <= lanes[lane_nx];
              out_last  <= cur_last && nx_end;
            end else if (rd_en) begin
              out_valid <= 1'b1;
              cur_word  <= rd_ent.word;
              cur_cnt   <= rd_ent.cnt;
              cur_last  <= rd_ent.last;
              lane      <= '0;
              out_index <= rd_ent.word[IDX_W-1:0];
              out_last  <= rd_ent.last &&
                           (rd_ent.cnt == CNT_W'(1));
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_index_stream_unpacker.sv
// tb_index_stream_unpacker: directed and random checks
// against a word-queue model of the unpacker.
module tb_index_stream_unpacker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_word = '0;
  logic [2:0]  in_count = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_index;
  logic        out_last;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;

  index_stream_unpacker #(
    .IDX_W        (16),
    .IDX_PER_WORD (4),
    .DEPTH        (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_count  (in_count),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: words waiting, plus the word being emitted.
  typedef struct {
    logic [63:0] w;
    int          cnt;
    logic        last;
  } mw_t;

  typedef struct {
    logic [15:0] idx;
    logic        last;
    int          cyc;
  } log_t;

  mw_t   mq[$];
  log_t  olog[$];
  bit    m_active = 0;
  mw_t   m_cur;
  int    m_pos = 0;
  int    cyc = 0;
  int    acc_cyc = 0;

  function automatic logic [15:0] m_idx();
    return 16'(m_cur.w >> (16 * m_pos));
  endfunction

  function automatic logic m_last();
    return m_cur.last && (m_pos == m_cur.cnt - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 0;
      m_pos = 0;
    end else begin
      int  sz0;
      int  c;
      bit  hs;
      mw_t nw;
      cyc++;
      sz0 = mq.size();
      hs = m_active && out_ready;
      if (hs) olog.push_back('{m_idx(), m_last(), cyc});
      if (flush) begin
        mq.delete();
        m_active = 0;
      end else begin
        if (hs) begin
          if (m_pos == m_cur.cnt - 1) m_active = 0;
          else m_pos++;
        end
        if (!m_active && sz0 > 0) begin
          m_cur = mq.pop_front();
          m_pos = 0;
          m_active = 1;
        end
        if (in_valid && sz0 < 4) begin
          c = (in_count > 4) ? 4 : int'(in_count);
          if (c > 0) begin
            nw.w = in_word;
            nw.cnt = c;
            nw.last = in_last;
            mq.push_back(nw);
          end
        end
      end
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", in_ready,
        (!flush && mq.size() < 4) ? 1 : 0);
    chk("level", level, mq.size());
    chk("out_valid", out_valid, m_active);
    if (m_active) begin
      chk("out_index", out_index, m_idx());
      chk("out_last", out_last, m_last());
    end
  end

  task automatic push(input logic [63:0] w,
                      input logic [2:0] c,
                      input logic l);
    bit a;
    a = 0;
    in_valid = 1;
    in_word = w;
    in_count = c;
    in_last = l;
    for (int n = 0; n < 100 && !a; n++) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
    end
    if (!a) chk("push_timeout", a, 1);
    acc_cyc = cyc;
    in_valid = 0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    out_ready = 1;
    in_valid = 0;
    while ((out_valid || level != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, out_valid, 0);
  endtask

  task automatic exp_log(input int i,
                         input logic [15:0] idx,
                         input logic lst);
    if (olog.size() <= i) begin
      chk("log_len", olog.size(), i + 1);
    end else begin
      chk("log_idx", olog[i].idx, idx);
      chk("log_last", olog[i].last, lst);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit acc;
    bit did_rst;
    int nw;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_level", level, 0);
    chk("t1_out_index", out_index, 0);
    chk("t1_out_last", out_last, 0);
    @(posedge clk);
    #1;

    // 2: one full word, streaming consumer
    olog.delete();
    out_ready = 1;
    push(64'h0004_0003_0002_0001, 3'd4, 1'b1);
    drain("t2_drain");
    chk("t2_len", olog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      exp_log(i, 16'(i + 1), (i == 3));
      if (olog.size() > i)
        chk("t2_cyc", olog[i].cyc, acc_cyc + 2 + i);
    end

    // 2b: count above lane total is clamped
    olog.delete();
    push(64'h0054_0053_0052_0051, 3'd7, 1'b1);
    drain("t2b_drain");
    chk("t2b_len", olog.size(), 4);
    exp_log(0, 16'h51, 0);
    exp_log(3, 16'h54, 1);

    // 3: back-to-back words incl. a zero-count word
    olog.delete();
    push(64'h0000_0000_0011_0010, 3'd2, 1'b0);
    push(64'hdead_beef_dead_beef, 3'd0, 1'b1);
    push(64'h0000_0022_0021_0020, 3'd3, 1'b1);
    drain("t3_drain");
    chk("t3_len", olog.size(), 5);
    exp_log(0, 16'h10, 0);
    exp_log(1, 16'h11, 0);
    exp_log(2, 16'h20, 0);
    exp_log(3, 16'h21, 0);
    exp_log(4, 16'h22, 1);
    if (olog.size() == 5)
      chk("t3_gap", olog[4].cyc - olog[0].cyc, 4);

    // 4: back-pressure fills the FIFO
    olog.delete();
    out_ready = 0;
    for (int i = 0; i < 5; i++)
      push(64'(16'h100 + i), 3'd1, 1'b1);
    in_valid = 1;
    in_word = 64'h105;
    in_count = 3'd1;
    in_last = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_level", level, 4);
      chk("t4_hold_idx", out_index, 16'h100);
      chk("t4_hold_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("t4_ready_after_pop", in_ready, 1);
    chk("t4_level_after_pop", level, 3);
    chk("t4_next_idx", out_index, 16'h101);
    @(posedge clk);
    #1 in_valid = 0;
    drain("t4_drain");
    chk("t4_len", olog.size(), 6);
    for (int i = 0; i < 6; i++)
      exp_log(i, 16'(16'h100 + i), 1);

    // 5: flush mid-word with a word offered
    olog.delete();
    out_ready = 1;
    push(64'h0034_0033_0032_0031, 3'd4, 1'b1);
    push(64'h0000_0000_0042_0041, 3'd2, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    flush = 1;
    in_valid = 1;
    in_word = 64'h77;
    in_count = 3'd1;
    in_last = 1;
    @(negedge clk);
    chk("t5_in_ready_flush", in_ready, 0);
    chk("t5_level_pre", level, 1);
    @(posedge clk);
    #1;
    flush = 0;
    in_valid = 0;
    @(negedge clk);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_level", level, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_len", olog.size(), 3);
    exp_log(0, 16'h31, 0);
    exp_log(1, 16'h32, 0);
    exp_log(2, 16'h33, 0);

    // 6: random traffic with one async reset
    nw = 0;
    did_rst = 0;
    for (int t = 0; t < 30000 && nw < 1000; t++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) nw++;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_word = {$urandom, $urandom};
        in_count = 3'($urandom_range(0, 7));
        in_last = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 63) == 0);
      if (nw == 500 && !did_rst) begin
        did_rst = 1;
        flush = 0;
        #2 rst_n = 0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_level", level, 0);
        in_valid = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1;
      end
    end
    chk("t6_words", nw, 1000);
    flush = 0;
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
